psum_accumulator: RTL and testbench

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

---
 rtl/slac_pkg.sv | 23 ++
 rtl/sat_add.sv | 40 ++++
 rtl/psum_accumulator.sv | 202 ++++++++++++++++++++
 tb/tb_psum_accumulator.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slac_pkg
//  Description : Shared types and constants for the psum accumulator slice.
//                Holds the accumulator FSM state encoding and the guard-bit
//                width used by the saturating adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package slac_pkg;

    // Accumulator control states; width is explicit so the encoding is stable.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // One extra bit is enough to hold the exact sum of two signed operands,
    // which lets overflow be detected from the top two bits of the wide sum.
    localparam int SAT_GUARD_BITS = 1;

endpackage
`default_nettype wire

// File: rtl/sat_add.sv
`default_nettype none
// ============================================================================
//  Module      : sat_add
//  Description : Combinational signed saturating adder. The result clamps to
//                the most positive / most negative representable value
//                instead of wrapping.
//  Ports       : a, b  - signed operands (DATA_WIDTH)
//                sum   - saturated signed sum (DATA_WIDTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_add
    import slac_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] sum
);

    localparam int c_wide_w = DATA_WIDTH + SAT_GUARD_BITS;
    localparam logic signed [DATA_WIDTH-1:0] c_pos_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] c_neg_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [c_wide_w-1:0] w_wide;

    always_comb begin
        w_wide = {{SAT_GUARD_BITS{a[DATA_WIDTH-1]}}, a}
               + {{SAT_GUARD_BITS{b[DATA_WIDTH-1]}}, b};
        // Overflow when the true sign (top bit) disagrees with the sign of
        // the truncated result; the true sign picks which rail to clamp to.
        if (w_wide[c_wide_w-1] != w_wide[DATA_WIDTH-1]) begin
            sum = w_wide[c_wide_w-1] ? c_neg_min : c_pos_max;
        end else begin
            sum = w_wide[DATA_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : psum_accumulator
//  Description : Collects partial sums from a PE cluster into an E x E flop
//                buffer across C input channels (first channel overwrites,
//                later channels saturating-add), then drains the tile in
//                raster order with a valid/ready handshake and optional ReLU.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                i_start               - latch E / C / relu and begin a tile
//                i_ofmap_dim           - ofmap side E (1..NUM_PES)
//                i_num_channels        - channel count C (1..MAX_CHANNELS)
//                i_relu_en             - clamp negatives to 0 on drain
//                i_peout_*             - incoming psum beat (data,valid,row,col)
//                o_out_*, i_out_ready  - drain stream (data,valid,row,col,last)
//                o_busy, o_done, o_err - status
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_accumulator
    import slac_pkg::*;
#(
    parameter  int DATA_WIDTH   = 16,
    parameter  int NUM_PES      = 16,
    parameter  int MAX_CHANNELS = 256,
    localparam int LOG_NPE      = $clog2(NUM_PES),
    localparam int LOG_MCH      = $clog2(MAX_CHANNELS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [LOG_NPE:0]      i_ofmap_dim,
    input  logic [LOG_MCH:0]      i_num_channels,
    input  logic                  i_relu_en,
    input  logic [DATA_WIDTH-1:0] i_peout_data,
    input  logic                  i_peout_valid,
    input  logic [LOG_NPE:0]      i_peout_row,
    input  logic [LOG_NPE:0]      i_peout_col,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_valid,
    output logic [LOG_NPE:0]      o_out_row,
    output logic [LOG_NPE:0]      o_out_col,
    output logic                  o_out_last,
    input  logic                  i_out_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int c_pos_w = LOG_NPE + 1;
    localparam int c_ch_w  = LOG_MCH + 1;
    // Buffer index width; a position that passed the range check always fits.
    localparam int c_idx_w = (LOG_NPE > 0) ? LOG_NPE : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [c_pos_w-1:0]     r_e;
    logic [c_ch_w-1:0]      r_c;
    logic                   r_relu;
    logic [c_ch_w-1:0]      r_chan;
    logic [c_pos_w-1:0]     r_rd_row;
    logic [c_pos_w-1:0]     r_rd_col;
    logic                   r_err;
    logic                   r_done;

    // Psum buffer: deliberately not reset; every tile rewrites it on channel 0.
    logic signed [DATA_WIDTH-1:0] r_buf [NUM_PES][NUM_PES];

    // ------------------------------------------------------------------
    // Accumulation path
    // ------------------------------------------------------------------
    logic [c_pos_w-1:0]           w_e_last;
    logic [c_ch_w-1:0]            w_c_last;
    logic                         w_in_range;
    logic                         w_beat_ok;
    logic                         w_beat_bad;
    logic                         w_beat_at_end;
    logic [c_idx_w-1:0]           w_wr_row;
    logic [c_idx_w-1:0]           w_wr_col;
    logic signed [DATA_WIDTH-1:0] w_old;
    logic signed [DATA_WIDTH-1:0] w_sum;
    logic signed [DATA_WIDTH-1:0] w_wr_data;

    assign w_e_last      = r_e - c_pos_w'(1);
    assign w_c_last      = r_c - c_ch_w'(1);
    assign w_in_range    = (i_peout_row < r_e) && (i_peout_col < r_e);
    assign w_beat_ok     = (r_state == ST_ACCUM) && i_peout_valid && w_in_range;
    // Any beat not accepted is an error: outside ACCUM or outside the tile.
    assign w_beat_bad    = i_peout_valid && !w_beat_ok;
    assign w_beat_at_end = (i_peout_row == w_e_last) && (i_peout_col == w_e_last);
    assign w_wr_row      = i_peout_row[c_idx_w-1:0];
    assign w_wr_col      = i_peout_col[c_idx_w-1:0];
    assign w_old         = r_buf[w_wr_row][w_wr_col];
    assign w_wr_data     = (r_chan == '0) ? i_peout_data : w_sum;

    sat_add #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sat_add (
        .a   (w_old),
        .b   (i_peout_data),
        .sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (!reset && w_beat_ok) begin
            r_buf[w_wr_row][w_wr_col] <= w_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Drain path: data comes straight from the buffer flops so the final
    // accumulation write is visible on the very first drain cycle.
    // ------------------------------------------------------------------
    logic                         w_drain;
    logic                         w_rd_last;
    logic signed [DATA_WIDTH-1:0] w_rd;

    assign w_drain   = (r_state == ST_DRAIN);
    assign w_rd_last = (r_rd_row == w_e_last) && (r_rd_col == w_e_last);
    assign w_rd      = r_buf[r_rd_row[c_idx_w-1:0]][r_rd_col[c_idx_w-1:0]];

    always_comb begin
        o_out_data = '0;
        if (w_drain && !(r_relu && w_rd[DATA_WIDTH-1])) begin
            o_out_data = w_rd;
        end
    end

    assign o_out_valid = w_drain;
    assign o_out_row   = r_rd_row;
    assign o_out_col   = r_rd_col;
    assign o_out_last  = w_drain && w_rd_last;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_err       = r_err;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_e      <= '0;
            r_c      <= '0;
            r_relu   <= 1'b0;
            r_chan   <= '0;
            r_rd_row <= '0;
            r_rd_col <= '0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_beat_bad) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_e      <= i_ofmap_dim;
                        r_c      <= i_num_channels;
                        r_relu   <= i_relu_en;
                        r_chan   <= '0;
                        r_rd_row <= '0;
                        r_rd_col <= '0;
                        // A new tile starts with a clean error flag.
                        r_err    <= 1'b0;
                        r_state  <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_beat_ok && w_beat_at_end) begin
                        if (r_chan == w_c_last) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_chan <= r_chan + c_ch_w'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (i_out_ready) begin
                        if (w_rd_last) begin
                            r_rd_row <= '0;
                            r_rd_col <= '0;
                            r_done   <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else if (r_rd_col == w_e_last) begin
                            r_rd_col <= '0;
                            r_rd_row <= r_rd_row + c_pos_w'(1);
                        end else begin
                            r_rd_col <= r_rd_col + c_pos_w'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_accumulator
//  Description : Self-checking bench for psum_accumulator. Single-position
//                tiles come from a vector table; multi-cycle cases (raster
//                drain, multi-channel sums, stall, errors, mid-drain reset)
//                are hand-written sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_accumulator;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_start;
    logic [4:0]    i_ofmap_dim;
    logic [8:0]    i_num_channels;
    logic          i_relu_en;
    logic [DW-1:0] i_peout_data;
    logic          i_peout_valid;
    logic [4:0]    i_peout_row;
    logic [4:0]    i_peout_col;
    logic [DW-1:0] o_out_data;
    logic          o_out_valid;
    logic [4:0]    o_out_row;
    logic [4:0]    o_out_col;
    logic          o_out_last;
    logic          i_out_ready;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    psum_accumulator #(
        .DATA_WIDTH   (DW),
        .NUM_PES      (16),
        .MAX_CHANNELS (256)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_start        (i_start),
        .i_ofmap_dim    (i_ofmap_dim),
        .i_num_channels (i_num_channels),
        .i_relu_en      (i_relu_en),
        .i_peout_data   (i_peout_data),
        .i_peout_valid  (i_peout_valid),
        .i_peout_row    (i_peout_row),
        .i_peout_col    (i_peout_col),
        .o_out_data     (o_out_data),
        .o_out_valid    (o_out_valid),
        .o_out_row      (o_out_row),
        .o_out_col      (o_out_col),
        .o_out_last     (o_out_last),
        .i_out_ready    (i_out_ready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err)
    );

    typedef struct {
        int c;      // channels (1 or 2), E is always 1
        int a;      // channel 0 value
        int b;      // channel 1 value (unused when c == 1)
        bit relu;
        int exp;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_tile(input int e, input int c, input bit relu);
        i_start        = 1'b1;
        i_ofmap_dim    = 5'(e);
        i_num_channels = 9'(c);
        i_relu_en      = relu;
        @(negedge clk);
        i_start        = 1'b0;
    endtask

    task automatic beat(input int r, input int c, input int d);
        i_peout_valid = 1'b1;
        i_peout_row   = 5'(r);
        i_peout_col   = 5'(c);
        i_peout_data  = DW'(d);
        @(negedge clk);
        i_peout_valid = 1'b0;
    endtask

    task automatic send_all(input int e, input int val);
        for (int r = 0; r < e; r++)
            for (int c = 0; c < e; c++)
                beat(r, c, val);
    endtask

    task automatic send_list(input int e, input int vals[$]);
        for (int k = 0; k < e * e; k++)
            beat(k / e, k % e, vals[k]);
    endtask

    // Drain a full tile with ready held high, then check the done pulse.
    task automatic drain_expect(input string tag, input int e, input int exp_q[$]);
        int wait_cyc;
        i_out_ready = 1'b1;
        for (int k = 0; k < e * e; k++) begin
            wait_cyc = 0;
            while (!o_out_valid && wait_cyc < 20) begin
                @(negedge clk);
                wait_cyc++;
            end
            if (!o_out_valid) begin
                check($sformatf("%s valid_timeout", tag), 0, 1);
                return;
            end
            check($sformatf("%s data[%0d]", tag, k), int'($signed(o_out_data)), exp_q[k]);
            check($sformatf("%s row[%0d]", tag, k), int'(o_out_row), k / e);
            check($sformatf("%s col[%0d]", tag, k), int'(o_out_col), k % e);
            check($sformatf("%s last[%0d]", tag, k), int'(o_out_last), (k == e * e - 1) ? 1 : 0);
            @(negedge clk);
        end
        check($sformatf("%s done_pulse", tag), int'(o_done), 1);
        check($sformatf("%s idle_busy", tag), int'(o_busy), 0);
        check($sformatf("%s idle_valid", tag), int'(o_out_valid), 0);
        @(negedge clk);
        check($sformatf("%s done_cleared", tag), int'(o_done), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " valid"}, int'(o_out_valid), 0);
        check({tag, " last"},  int'(o_out_last), 0);
        check({tag, " busy"},  int'(o_busy), 0);
        check({tag, " done"},  int'(o_done), 0);
        check({tag, " err"},   int'(o_err), 0);
        check({tag, " data"},  int'(o_out_data), 0);
        check({tag, " row"},   int'(o_out_row), 0);
        check({tag, " col"},   int'(o_out_col), 0);
    endtask

    initial begin
        int q[$];

        vecs[0]  = '{c: 2, a:  30000, b:  30000, relu: 1'b0, exp:  32767};
        vecs[1]  = '{c: 2, a: -30000, b: -30000, relu: 1'b0, exp: -32768};
        vecs[2]  = '{c: 2, a: -30000, b: -30000, relu: 1'b1, exp:      0};
        vecs[3]  = '{c: 2, a:  32767, b:      1, relu: 1'b0, exp:  32767};
        vecs[4]  = '{c: 2, a: -32768, b:     -1, relu: 1'b0, exp: -32768};
        vecs[5]  = '{c: 2, a:    100, b:    -50, relu: 1'b0, exp:     50};
        vecs[6]  = '{c: 2, a:     -5, b:      3, relu: 1'b0, exp:     -2};
        vecs[7]  = '{c: 2, a:     -5, b:      3, relu: 1'b1, exp:      0};
        vecs[8]  = '{c: 1, a:   1234, b:      0, relu: 1'b0, exp:   1234};
        vecs[9]  = '{c: 1, a:     -7, b:      0, relu: 1'b1, exp:      0};
        vecs[10] = '{c: 2, a:  32767, b: -32768, relu: 1'b0, exp:     -1};

        reset          = 1'b1;
        i_start        = 1'b0;
        i_ofmap_dim    = '0;
        i_num_channels = '0;
        i_relu_en      = 1'b0;
        i_peout_data   = '0;
        i_peout_valid  = 1'b0;
        i_peout_row    = '0;
        i_peout_col    = '0;
        i_out_ready    = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Basic 2x2 single-channel tile, distinct values in raster order.
        start_tile(2, 1, 1'b0);
        check("t1 busy_after_start", int'(o_busy), 1);
        check("t1 err_after_start", int'(o_err), 0);
        q = '{1, 2, 3, 4};
        send_list(2, q);
        drain_expect("t1", 2, q);

        // Three channels of 5 sum to 15, then a one-channel tile overwrites.
        start_tile(2, 3, 1'b0);
        for (int ch = 0; ch < 3; ch++) send_all(2, 5);
        q = '{15, 15, 15, 15};
        drain_expect("t2", 2, q);
        start_tile(2, 1, 1'b0);
        send_all(2, 7);
        q = '{7, 7, 7, 7};
        drain_expect("t3", 2, q);

        // Single-position tiles from the table: saturation, relu, E=C=1.
        for (int i = 0; i < 11; i++) begin
            start_tile(1, vecs[i].c, vecs[i].relu);
            beat(0, 0, vecs[i].a);
            if (vecs[i].c == 2) beat(0, 0, vecs[i].b);
            q = '{vecs[i].exp};
            drain_expect($sformatf("vec%0d", i), 1, q);
        end

        // Error handling: a beat while idle, then an out-of-tile beat.
        beat(0, 0, 55);
        check("err idle_beat", int'(o_err), 1);
        check("err idle_stays_idle", int'(o_busy), 0);
        start_tile(2, 1, 1'b0);
        check("err cleared_by_start", int'(o_err), 0);
        beat(3, 0, 99);
        check("err row_out_of_range", int'(o_err), 1);
        check("err still_accum", int'(o_out_valid), 0);
        q = '{11, 12, 13, 14};
        send_list(2, q);
        drain_expect("err_tile", 2, q);
        check("err sticky_after_drain", int'(o_err), 1);

        // Drain stall: ready pattern 1,0,0,1 then held high.
        start_tile(2, 1, 1'b0);
        check("stall err_cleared", int'(o_err), 0);
        q = '{10, 20, 30, 40};
        send_list(2, q);
        i_out_ready = 1'b1;
        check("stall b0 data", int'($signed(o_out_data)), 10);
        @(negedge clk);
        i_out_ready = 1'b0;
        check("stall b1 data", int'($signed(o_out_data)), 20);
        @(negedge clk);
        check("stall hold1 data", int'($signed(o_out_data)), 20);
        check("stall hold1 col", int'(o_out_col), 1);
        check("stall hold1 valid", int'(o_out_valid), 1);
        @(negedge clk);
        check("stall hold2 data", int'($signed(o_out_data)), 20);
        check("stall hold2 row", int'(o_out_row), 0);
        i_out_ready = 1'b1;
        @(negedge clk);
        check("stall b2 data", int'($signed(o_out_data)), 30);
        check("stall b2 row", int'(o_out_row), 1);
        check("stall b2 col", int'(o_out_col), 0);
        @(negedge clk);
        check("stall b3 data", int'($signed(o_out_data)), 40);
        check("stall b3 last", int'(o_out_last), 1);
        @(negedge clk);
        check("stall done", int'(o_done), 1);
        @(negedge clk);
        check("stall done_cleared", int'(o_done), 0);

        // Reset in the middle of a drain, then a fresh tile.
        start_tile(2, 1, 1'b0);
        q = '{1, 2, 3, 4};
        send_list(2, q);
        i_out_ready = 1'b1;
        check("rst b0 data", int'($signed(o_out_data)), 1);
        @(negedge clk);
        check("rst b1 data", int'($signed(o_out_data)), 2);
        @(negedge clk);
        check("rst b2 presented", int'($signed(o_out_data)), 3);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_drain_reset");
        reset = 1'b0;
        @(negedge clk);
        check("rst no_done", int'(o_done), 0);
        check("rst idle", int'(o_busy), 0);
        start_tile(2, 1, 1'b0);
        q = '{5, 6, 7, 8};
        send_list(2, q);
        drain_expect("after_reset", 2, q);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a sequence wedges.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
